// File: rtl/demux_1x4_rx.sv
// demux_1x4_rx: 1:4 byte demultiplexer for the phy_rx lane.
// Steers a byte stream round-robin onto four lanes, updated together per frame.
module demux_1x4_rx #(
    parameter int BW = 8
) (
    input  logic          clk_4f,
    input  logic          reset,
    input  logic          sync,
    input  logic          validEntrada,
    input  logic [BW-1:0] Entrada,
    output logic [BW-1:0] Salida0,
    output logic [BW-1:0] Salida1,
    output logic [BW-1:0] Salida2,
    output logic [BW-1:0] Salida3,
    output logic          validSalida0,
    output logic          validSalida1,
    output logic          validSalida2,
    output logic          validSalida3,
    output logic          frame_stb
);

    logic [1:0]    phase;
    logic [1:0]    cur_phase;
    logic [BW-1:0] hold0;
    logic [BW-1:0] hold1;
    logic [BW-1:0] hold2;
    logic          hvalid0;
    logic          hvalid1;
    logic          hvalid2;

    // sync realigns in the same cycle it is seen
    assign cur_phase = sync ? 2'd0 : phase;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            phase        <= '0;
            hold0        <= '0;
            hold1        <= '0;
            hold2        <= '0;
            hvalid0      <= 1'b0;
            hvalid1      <= 1'b0;
            hvalid2      <= 1'b0;
            Salida0      <= '0;
            Salida1      <= '0;
            Salida2      <= '0;
            Salida3      <= '0;
            validSalida0 <= 1'b0;
            validSalida1 <= 1'b0;
            validSalida2 <= 1'b0;
            validSalida3 <= 1'b0;
            frame_stb    <= 1'b0;
        end else begin
            phase     <= cur_phase + 2'd1;
            frame_stb <= 1'b0;
            unique case (cur_phase)
                2'd0: begin
                    if (validEntrada) hold0 <= Entrada;
                    hvalid0 <= validEntrada;
                end
                2'd1: begin
                    if (validEntrada) hold1 <= Entrada;
                    hvalid1 <= validEntrada;
                end
                2'd2: begin
                    if (validEntrada) hold2 <= Entrada;
                    hvalid2 <= validEntrada;
                end
                2'd3: begin
                    // lane 3 bypasses the holding buffers
                    Salida0      <= hold0;
                    Salida1      <= hold1;
                    Salida2      <= hold2;
                    validSalida0 <= hvalid0;
                    validSalida1 <= hvalid1;
                    validSalida2 <= hvalid2;
                    if (validEntrada) Salida3 <= Entrada;
                    validSalida3 <= validEntrada;
                    frame_stb    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_1x4_rx.sv
// tb_demux_1x4_rx: directed stimulus, frame-level model and
// per-cycle comparison for demux_1x4_rx.
module tb_demux_1x4_rx;

    localparam int BW = 8;

    logic          clk_4f = 1'b0;
    logic          reset = 1'b1;
    logic          sync = 1'b0;
    logic          validEntrada = 1'b0;
    logic [BW-1:0] Entrada = '0;
    logic [BW-1:0] Salida0, Salida1, Salida2, Salida3;
    logic          validSalida0, validSalida1, validSalida2, validSalida3;
    logic          frame_stb;

    int checks = 0;
    int errors = 0;

    demux_1x4_rx #(.BW(BW)) dut (
        .clk_4f       (clk_4f),
        .reset        (reset),
        .sync         (sync),
        .validEntrada (validEntrada),
        .Entrada      (Entrada),
        .Salida0      (Salida0),
        .Salida1      (Salida1),
        .Salida2      (Salida2),
        .Salida3      (Salida3),
        .validSalida0 (validSalida0),
        .validSalida1 (validSalida1),
        .validSalida2 (validSalida2),
        .validSalida3 (validSalida3),
        .frame_stb    (frame_stb)
    );

    always #5 clk_4f = ~clk_4f;

    // Model: each lane shows the most recent valid byte that arrived at
    // that frame position, snapshotted when the 4th byte of a frame lands.
    logic [BW-1:0] last_byte [4];
    logic          last_vld  [4];
    logic [BW-1:0] exp_out   [4];
    logic          exp_vld   [4];
    logic          exp_stb;
    int            pos;
    bit            started = 0;

    always @(posedge clk_4f) begin
        int p;
        started = 1;
        exp_stb = 1'b0;
        if (reset) begin
            pos = 0;
            for (int i = 0; i < 4; i++) begin
                last_byte[i] = '0;
                last_vld[i]  = 1'b0;
                exp_out[i]   = '0;
                exp_vld[i]   = 1'b0;
            end
        end else begin
            p = sync ? 0 : pos;
            if (validEntrada) last_byte[p] = Entrada;
            last_vld[p] = validEntrada;
            if (p == 3) begin
                for (int i = 0; i < 4; i++) begin
                    exp_out[i] = last_byte[i];
                    exp_vld[i] = last_vld[i];
                end
                exp_stb = 1'b1;
            end
            pos = (p + 1) % 4;
        end
    end

    task automatic cmp(input string name, input logic [BW-1:0] got,
                       input logic [BW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    always @(negedge clk_4f) begin
        if (started) begin
            cmp("m_Salida0", Salida0, exp_out[0]);
            cmp("m_Salida1", Salida1, exp_out[1]);
            cmp("m_Salida2", Salida2, exp_out[2]);
            cmp("m_Salida3", Salida3, exp_out[3]);
            cmp("m_valid0", BW'(validSalida0), BW'(exp_vld[0]));
            cmp("m_valid1", BW'(validSalida1), BW'(exp_vld[1]));
            cmp("m_valid2", BW'(validSalida2), BW'(exp_vld[2]));
            cmp("m_valid3", BW'(validSalida3), BW'(exp_vld[3]));
            cmp("m_frame_stb", BW'(frame_stb), BW'(exp_stb));
        end
    end

    task automatic step(input logic s, input logic v, input logic [BW-1:0] d);
        sync         = s;
        validEntrada = v;
        Entrada      = d;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic lit(input string tag, input logic [BW-1:0] s0,
                       input logic [BW-1:0] s1, input logic [BW-1:0] s2,
                       input logic [BW-1:0] s3, input logic [3:0] v,
                       input logic stb);
        cmp({tag, "_s0"}, Salida0, s0);
        cmp({tag, "_s1"}, Salida1, s1);
        cmp({tag, "_s2"}, Salida2, s2);
        cmp({tag, "_s3"}, Salida3, s3);
        cmp({tag, "_v"},
            BW'({validSalida3, validSalida2, validSalida1, validSalida0}),
            BW'(v));
        cmp({tag, "_stb"}, BW'(frame_stb), BW'(stb));
    endtask

    initial begin
        // reset held 3 cycles with a busy line
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'hFF);
            lit("rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0);
        end
        reset = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        lit("post_rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0);

        // aligned A frame, then B frame on schedule
        step(1'b1, 1'b1, 8'hA0);
        step(1'b0, 1'b1, 8'hA1);
        step(1'b0, 1'b1, 8'hA2);
        step(1'b0, 1'b1, 8'hA3);
        lit("A", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'hF, 1'b1);
        step(1'b0, 1'b1, 8'hB0);
        lit("A_hold", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'hF, 1'b0);
        step(1'b0, 1'b1, 8'hB1);
        step(1'b0, 1'b1, 8'hB2);
        lit("A_hold3", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'hF, 1'b0);
        step(1'b0, 1'b1, 8'hB3);
        lit("B", 8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'hF, 1'b1);

        // invalid byte in lane 2
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b0, 8'hEE);
        step(1'b0, 1'b1, 8'h13);
        lit("gap", 8'h10, 8'h11, 8'hB2, 8'h13, 4'b1011, 1'b1);

        // realign after two bytes
        step(1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b1, 8'h21);
        step(1'b1, 1'b1, 8'hC0);
        step(1'b0, 1'b1, 8'hC1);
        step(1'b0, 1'b1, 8'hC2);
        lit("trunc", 8'h10, 8'h11, 8'hB2, 8'h13, 4'b1011, 1'b0);
        step(1'b0, 1'b1, 8'hC3);
        lit("C", 8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'hF, 1'b1);

        // sync on what would be phase 3 truncates without commit
        step(1'b0, 1'b1, 8'h30);
        step(1'b0, 1'b1, 8'h31);
        step(1'b0, 1'b1, 8'h32);
        step(1'b1, 1'b1, 8'h40);
        lit("sync_p3", 8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'hF, 1'b0);
        step(1'b0, 1'b1, 8'h41);
        step(1'b0, 1'b1, 8'h42);
        step(1'b0, 1'b1, 8'h43);
        lit("F40", 8'h40, 8'h41, 8'h42, 8'h43, 4'hF, 1'b1);

        // reset mid-frame discards D0/D1
        step(1'b0, 1'b1, 8'hD0);
        step(1'b0, 1'b1, 8'hD1);
        reset = 1'b1;
        step(1'b1, 1'b1, 8'hD2);
        reset = 1'b0;
        lit("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0);
        step(1'b1, 1'b1, 8'hE0);
        step(1'b0, 1'b1, 8'hE1);
        step(1'b0, 1'b1, 8'hE2);
        lit("pre_E", 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0);
        step(1'b0, 1'b1, 8'hE3);
        lit("E", 8'hE0, 8'hE1, 8'hE2, 8'hE3, 4'hF, 1'b1);

        // idle line: empty frames still commit
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h5A);
            if (i == 3 || i == 7)
                lit("idle", 8'hE0, 8'hE1, 8'hE2, 8'hE3, 4'h0, 1'b1);
        end
        step(1'b0, 1'b0, 8'h00);
        lit("idle_end", 8'hE0, 8'hE1, 8'hE2, 8'hE3, 4'h0, 1'b0);

        @(negedge clk_4f);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
